proc_sequencer: RTL and testbench

//   Program sequencer for the 16-bit Processor datapath. Holds a small program

---
 rtl/proc_pkg.sv | 35 +++
 rtl/proc_prog_mem.sv | 24 ++
 rtl/proc_sequencer.sv | 151 +++++++++++++++
 tb/tb_proc_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor: opcode fields, op codes, idle opcode and
// sequencer state encodings.
package proc_pkg;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 13;
  localparam int unsigned RA_MSB  = 12;
  localparam int unsigned RA_LSB  = 10;
  localparam int unsigned RB_MSB  = 9;
  localparam int unsigned RB_LSB  = 7;
  localparam int unsigned RC_MSB  = 6;
  localparam int unsigned RC_LSB  = 4;
  localparam int unsigned IMM_MSB = 3;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SUBI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  // ADDI r0,r0,0: architecturally a no-op
  localparam logic [15:0] IDLE_OP_DEFAULT = 16'b001_000_000_000_0000;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIssue = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
  localparam logic [2:0] StPause = 3'd4;

  function automatic logic [2:0] get_op(input logic [15:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/proc_prog_mem.sv
// Program memory: DEPTH x 16 array, synchronous write, asynchronous read, no reset.
module proc_prog_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/proc_sequencer.sv
// Program sequencer: issues opcodes from a host-loaded program memory to the datapath and
// captures each result. Optional single-step mode is enabled by defining SEQ_SINGLE_STEP_EN.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = $clog2(DEPTH),
  parameter int unsigned RESULT_LAT = 1,
  parameter logic [15:0] IDLE_OP    = IDLE_OP_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [15:0]   prog_data_i,
  input  logic          start_i,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic          step_i,
`endif
  output logic          busy_o,
  output logic          done_o,
  output logic [15:0]   opcode_o,
  input  logic [15:0]   proc_result_i,
  output logic          res_valid_o,
  output logic [15:0]   res_data_o,
  output logic [AW-1:0] res_pc_o
);

  localparam int unsigned CW = $clog2(RESULT_LAT + 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   opcode_q, opcode_d;
  logic          busy_q, busy_d;
  logic          res_valid_q, res_valid_d;
  logic [15:0]   res_data_q, res_data_d;
  logic [AW-1:0] res_pc_q, res_pc_d;
  logic [15:0]   instr;
  logic          last_pc;

  proc_prog_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_prog_mem (
    .clk_i  (clk),
    .we_i   (prog_we_i && (state_q == StIdle)),
    .waddr_i(prog_addr_i),
    .wdata_i(prog_data_i),
    .raddr_i(pc_q),
    .rdata_o(instr)
  );

  assign last_pc = (pc_q == AW'(DEPTH - 1));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    opcode_d    = opcode_q;
    busy_d      = busy_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_pc_d    = res_pc_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          pc_d    = '0;
          busy_d  = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (get_op(instr) == OP_HALT) begin
          state_d = StDone;
        end else begin
          opcode_d = instr;
          cnt_d    = CW'(RESULT_LAT);
          state_d  = StWait;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          res_data_d  = proc_result_i;
          res_pc_d    = pc_q;
          res_valid_d = 1'b1;
          opcode_d    = IDLE_OP;
`ifdef SEQ_SINGLE_STEP_EN
          state_d     = StPause;
`else
          if (last_pc) begin
            state_d = StDone;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = StIssue;
          end
`endif
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      StPause: begin
        if (step_i) begin
          if (last_pc) begin
            state_d = StDone;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = StIssue;
          end
        end
      end
`endif
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      cnt_q       <= '0;
      opcode_q    <= IDLE_OP;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_pc_q    <= res_pc_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = (state_q == StDone);
  assign opcode_o    = opcode_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_pc_o    = res_pc_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer; exercises SEQ_SINGLE_STEP_EN when it is defined.
module tb_proc_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int RL    = 1;
  localparam logic [15:0] IDLE = 16'h2000;
`ifdef SEQ_SINGLE_STEP_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif
  localparam int STRIDE = RL + 2 + PX;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic          busy, done, res_valid;
  logic [15:0]   opcode, res_data;
  logic [15:0]   proc_result = 16'h0;
  logic [AW-1:0] res_pc;

  int errors = 0;
  int checks = 0;
  logic [15:0] key;
  logic [15:0] model_mem [DEPTH];

  typedef struct {
    logic [15:0] p0, p1, p2, p3;
    int          results;
    int          done_cyc;
  } vec_t;
  vec_t tbl [4];

  proc_sequencer #(.DEPTH(DEPTH), .AW(AW), .RESULT_LAT(RL), .IDLE_OP(IDLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .prog_we_i    (prog_we),
    .prog_addr_i  (prog_addr),
    .prog_data_i  (prog_data),
    .start_i      (start),
`ifdef SEQ_SINGLE_STEP_EN
    .step_i       (step),
`endif
    .busy_o       (busy),
    .done_o       (done),
    .opcode_o     (opcode),
    .proc_result_i(proc_result),
    .res_valid_o  (res_valid),
    .res_data_o   (res_data),
    .res_pc_o     (res_pc)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: result is a keyed function of the opcode, RL edges later
  always @(posedge clk) proc_result <= opcode ^ key;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = AW'(i);
      prog_data = model_mem[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Run the loaded program and check every cycle against timing derived from the cost rule
  task automatic run_prog(input int inject, input int exp_results, input int exp_done,
                          input bit use_tbl);
    int n, done_exp, rcount, dseen, sk;
    bit halted, exp_rv;
    logic [15:0] exp_op, exp_rd;
    logic [AW-1:0] exp_pc;
    n = 0; halted = 0; rcount = 0; dseen = -1;
    for (int k = 0; k < DEPTH; k++) begin
      if (model_mem[k][15:13] == 3'b111) begin
        halted = 1;
        break;
      end
      n++;
    end
    done_exp = halted ? 2 + STRIDE * n : 1 + STRIDE * (n - 1) + RL + 2 + PX;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c <= done_exp + 1; c++) begin
      exp_rv = 0; exp_op = IDLE; exp_rd = '0; exp_pc = '0;
      for (int k = 0; k < n; k++) begin
        sk = 1 + STRIDE * k;
        if (c >= sk + 1 && c <= sk + 1 + RL) exp_op = model_mem[k];
        if (c == sk + RL + 2) begin
          exp_rv = 1; exp_rd = model_mem[k] ^ key; exp_pc = AW'(k);
        end
      end
      check($sformatf("cyc%0d busy/done/rv/opcode", c), 32'({busy, done, res_valid, opcode}),
            32'({(c <= done_exp), (c == done_exp), exp_rv, exp_op}));
      if (exp_rv) begin
        check($sformatf("cyc%0d res_data", c), 32'(res_data), 32'(exp_rd));
        check($sformatf("cyc%0d res_pc", c), 32'(res_pc), 32'(exp_pc));
      end
      if (res_valid === 1'b1) rcount++;
      if (done === 1'b1 && dseen < 0) dseen = c;
      if (c == inject) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = AW'(3); prog_data = 16'hE000;
      end else if (c == inject + 1) begin
        start = 1'b0; prog_we = 1'b0;
      end
      if (c <= done_exp) @(negedge clk);
    end
    if (use_tbl) begin
      check("result count", 32'(rcount), 32'(exp_results));
      check("done cycle", 32'(dseen), 32'(exp_done + PX * exp_results));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy/done/rv"}, 32'({busy, done, res_valid}), 32'(0));
    check({tag, " opcode"}, 32'(opcode), 32'(IDLE));
    check({tag, " res_data/res_pc"}, 32'({res_data, res_pc}), 32'(0));
  endtask

  task automatic fill_tbl(input int i);
    model_mem[0] = tbl[i].p0; model_mem[1] = tbl[i].p1;
    model_mem[2] = tbl[i].p2; model_mem[3] = tbl[i].p3;
    for (int k = 4; k < DEPTH; k++) model_mem[k] = 16'hE000;
  endtask

  initial begin
    int waited;
    bit seen;
    key = 16'($urandom);
    step = (PX != 0);
    tbl[0] = '{16'h0140, 16'h2081, 16'h4081, 16'hE000, 3, 11};
    tbl[1] = '{16'hE000, 16'h0140, 16'h0140, 16'h0140, 0, 2};
    tbl[2] = '{16'h2081, 16'hE000, 16'h0140, 16'h0140, 1, 5};
    tbl[3] = '{16'h0140, 16'h6081, 16'hE123, 16'h2000, 2, 8};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      fill_tbl(i);
      load_mem();
      run_prog(-1, tbl[i].results, tbl[i].done_cyc, 1);
    end

    // Full memory with no HALT: must stop at the last address without wrapping
    for (int k = 0; k < DEPTH; k++) model_mem[k] = {3'b001, 13'($urandom)};
    load_mem();
    run_prog(-1, 16, 49, 1);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if ($urandom_range(0, 11) == 0) model_mem[k] = {3'b111, 13'($urandom)};
        else model_mem[k] = {1'b0, 2'($urandom), 13'($urandom)};
      end
      load_mem();
      run_prog(-1, 0, 0, 0);
    end

    // start/prog_we while busy are ignored; second run reads back mem[3]
    for (int k = 0; k < DEPTH; k++) model_mem[k] = {3'b010, 13'($urandom)};
    load_mem();
    run_prog(5, 16, 49, 1);
    run_prog(-1, 16, 49, 1);

    // Asynchronous reset during WAIT aborts immediately
    fill_tbl(0);
    load_mem();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre-reset opcode", 32'(opcode), 32'(16'h0140));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid-run reset");
    @(negedge clk) rst_n = 1'b1;
    run_prog(-1, 3, 11, 1);

`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 0;
    for (waited = 0; waited < 20 && !seen; waited++) begin
      if (res_valid === 1'b1) seen = 1;
      else @(negedge clk);
    end
    check("first res_valid seen", 32'(seen), 32'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("pause%0d busy/opcode/rv", i), 32'({busy, res_valid, opcode}),
            32'({1'b1, 1'b0, IDLE}));
    end
    step = 1'b1;
    @(negedge clk) step = 1'b0;
    @(negedge clk);
    check("opcode after step", 32'(opcode), 32'(16'h2081));
    step = 1'b1;
    seen = 0;
    for (waited = 0; waited < 40 && !seen; waited++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    check("step-mode done seen", 32'(seen), 32'(1));
    @(negedge clk);
    check("step-mode busy after done", 32'(busy), 32'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
